// File: rtl/ram_port_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | ram_port_arbiter: two-requester round-robin front end for a dual-port RAM,  |
// | with a tagged read-return path and a hardware clear sequencer.              |
// | Revision: 1.0                                                               |
// +----------------------------------------------------------------------------+
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8,
    parameter int RD_LAT     = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  m0_valid,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ready,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ready,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    input  logic                  clr_start,
    output logic                  clr_busy,
    output logic                  clr_done,
    output logic                  wr_enb,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  rd_enb,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [DATA_WIDTH-1:0] rd_data
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] c_last_addr = {ADDR_WIDTH{1'b1}};

    state_t                r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;
    logic                  r_wr_last;
    logic                  r_rd_last;
    logic [RD_LAT:0]       r_tag_vld;
    logic [RD_LAT:0]       r_tag_id;

    logic w_arb_en;
    logic w_wr_req0, w_wr_req1, w_rd_req0, w_rd_req1;
    logic w_wr_gnt0, w_wr_gnt1, w_rd_gnt0, w_rd_gnt1;
    logic w_ret0, w_ret1;

    // The pointer holds the id last granted, so the other requester wins a tie.
    assign w_arb_en  = (r_state == ST_IDLE) && !clr_start;
    assign w_wr_req0 = m0_valid &&  m0_we;
    assign w_wr_req1 = m1_valid &&  m1_we;
    assign w_rd_req0 = m0_valid && !m0_we;
    assign w_rd_req1 = m1_valid && !m1_we;
    assign w_wr_gnt0 = w_arb_en && w_wr_req0 && (!w_wr_req1 ||  r_wr_last);
    assign w_wr_gnt1 = w_arb_en && w_wr_req1 && (!w_wr_req0 || !r_wr_last);
    assign w_rd_gnt0 = w_arb_en && w_rd_req0 && (!w_rd_req1 ||  r_rd_last);
    assign w_rd_gnt1 = w_arb_en && w_rd_req1 && (!w_rd_req0 || !r_rd_last);

    assign m0_ready = w_wr_gnt0 || w_rd_gnt0;
    assign m1_ready = w_wr_gnt1 || w_rd_gnt1;
    assign clr_busy = (r_state != ST_IDLE);

    assign w_ret0 = r_tag_vld[RD_LAT] && !r_tag_id[RD_LAT];
    assign w_ret1 = r_tag_vld[RD_LAT] &&  r_tag_id[RD_LAT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= ST_IDLE;
            r_clr_cnt <= '0;
            r_wr_last <= 1'b1;
            r_rd_last <= 1'b1;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
            wr_enb    <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_enb    <= 1'b0;
            rd_addr   <= '0;
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            clr_done  <= 1'b0;
        end else begin
            wr_enb   <= 1'b0;
            rd_enb   <= 1'b0;
            clr_done <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (clr_start) begin
                        r_state   <= ST_CLEAR;
                        r_clr_cnt <= '0;
                    end
                end
                ST_CLEAR: begin
                    wr_enb    <= 1'b1;
                    wr_addr   <= r_clr_cnt;
                    wr_data   <= '0;
                    r_clr_cnt <= r_clr_cnt + 1'b1;
                    if (r_clr_cnt == c_last_addr) begin
                        r_state  <= ST_DONE;
                        clr_done <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase

            if (w_wr_gnt0 || w_wr_gnt1) begin
                wr_enb    <= 1'b1;
                wr_addr   <= w_wr_gnt0 ? m0_addr  : m1_addr;
                wr_data   <= w_wr_gnt0 ? m0_wdata : m1_wdata;
                r_wr_last <= w_wr_gnt1;
            end

            if (w_rd_gnt0 || w_rd_gnt1) begin
                rd_enb    <= 1'b1;
                rd_addr   <= w_rd_gnt0 ? m0_addr : m1_addr;
                r_rd_last <= w_rd_gnt1;
            end

            // Tags keep flowing regardless of FSM state so in-flight reads survive a clear.
            r_tag_vld <= {r_tag_vld[RD_LAT-1:0], w_rd_gnt0 || w_rd_gnt1};
            r_tag_id  <= {r_tag_id[RD_LAT-1:0], w_rd_gnt1};

            m0_rvalid <= w_ret0;
            m1_rvalid <= w_ret1;
            if (w_ret0) begin
                m0_rdata <= rd_data;
            end
            if (w_ret1) begin
                m1_rdata <= rd_data;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_port_arbiter.sv
`default_nettype none
// Self-checking bench for ram_port_arbiter: directed scenarios plus a randomized
// run compared against a transaction-level model of arbitration and RAM contents.
module tb_ram_port_arbiter;
    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int RL    = 1;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          m0_valid, m0_we, m0_ready, m0_rvalid;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic          m1_valid, m1_we, m1_ready, m1_rvalid;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic          clr_start, clr_busy, clr_done;
    logic          wr_enb, rd_enb;
    logic [AW-1:0] wr_addr, rd_addr;
    logic [DW-1:0] wr_data;
    logic [DW-1:0] rd_data = '0;
    logic [DW-1:0] mem [DEPTH] = '{default: '0};

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int          due;
        bit          id;
        logic [DW-1:0] data;
    } resp_t;

    always #5 clk = ~clk;

    ram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RD_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .wr_enb(wr_enb), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_enb(rd_enb), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // RAM with one cycle of read latency and read-before-write behaviour.
    always @(posedge clk) begin
        if (wr_enb) mem[wr_addr] <= wr_data;
        if (rd_enb) rd_data <= mem[rd_addr];
    end

    task automatic idle_inputs();
        m0_valid = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
        clr_start = 0;
    endtask

    task automatic drive_m(input bit who, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (!who) begin m0_valid = v; m0_we = we; m0_addr = a; m0_wdata = d; end
        else      begin m1_valid = v; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    // Issue one request and hold it until accepted; returns at the negedge after acceptance.
    task automatic m_req(input bit who, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got;
        got = 0;
        drive_m(who, 1'b1, we, a, d);
        for (int i = 0; i < 40 && !got; i++) begin
            #1 got = who ? m1_ready : m0_ready;
            @(negedge clk);
        end
        drive_m(who, 1'b0, we, a, d);
        n_tests++;
        if (!got) begin n_fail++; $display("FAIL req_timeout who=%0d ready_seen=0 required=1", who); end
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle_inputs();
        rst = 0;
        repeat (2) @(negedge clk);
        rst = 1;
    endtask

    task automatic test_reset();
        logic [63:0] all;
        idle_inputs();
        repeat (2) @(negedge clk);
        all = {wr_enb, wr_addr, wr_data, rd_enb, rd_addr, m0_rvalid, m1_rvalid,
               m0_rdata, m1_rdata, clr_busy, clr_done, m0_ready, m1_ready};
        n_tests++;
        if (all !== 64'd0) begin n_fail++; $display("FAIL reset_outputs got=%h required=0", all); end
        rst = 1;
        @(negedge clk);
        n_tests++;
        if ({wr_enb, rd_enb, clr_busy} !== 3'b000) begin
            n_fail++; $display("FAIL reset_release got=%b required=000", {wr_enb, rd_enb, clr_busy});
        end
    endtask

    task automatic test_single_write_read();
        @(negedge clk);
        drive_m(0, 1, 1, 4'd3, 8'hA5);
        #1;
        n_tests++;
        if ({m0_ready, m1_ready} !== 2'b10) begin n_fail++; $display("FAIL swr_wready got=%b required=10", {m0_ready, m1_ready}); end
        @(negedge clk);
        n_tests++;
        if ({wr_enb, wr_addr, wr_data} !== {1'b1, 4'd3, 8'hA5}) begin
            n_fail++; $display("FAIL swr_wport got=%b/%0d/%h required=1/3/a5", wr_enb, wr_addr, wr_data);
        end
        drive_m(0, 1, 0, 4'd3, 8'h00);
        #1;
        n_tests++;
        if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL swr_rready got=%b required=1", m0_ready); end
        @(negedge clk);
        drive_m(0, 0, 0, 4'd0, 8'h00);
        n_tests++;
        if ({rd_enb, rd_addr, m0_rvalid} !== {1'b1, 4'd3, 1'b0}) begin
            n_fail++; $display("FAIL swr_rport got=%b/%0d/%b required=1/3/0", rd_enb, rd_addr, m0_rvalid);
        end
        @(negedge clk);
        n_tests++;
        if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL swr_early_rvalid got=%b required=0", m0_rvalid); end
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 8'hA5, 1'b0}) begin
            n_fail++; $display("FAIL swr_resp got=%b/%h/%b required=1/a5/0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        @(negedge clk);
        n_tests++;
        if (m0_rvalid !== 1'b0) begin n_fail++; $display("FAIL swr_pulse got=%b required=0", m0_rvalid); end
    endtask

    task automatic test_write_contention();
        bit exp0;
        drive_m(0, 1, 1, 4'd1, 8'h11);
        drive_m(1, 1, 1, 4'd2, 8'h22);
        for (int i = 0; i < 4; i++) begin
            exp0 = (i % 2 == 0);
            #1;
            n_tests++;
            if ({m0_ready, m1_ready} !== {exp0, !exp0}) begin
                n_fail++; $display("FAIL contention_ready[%0d] got=%b required=%b", i, {m0_ready, m1_ready}, {exp0, !exp0});
            end
            @(negedge clk);
            n_tests++;
            if ({wr_enb, wr_addr, wr_data} !== (exp0 ? {1'b1, 4'd1, 8'h11} : {1'b1, 4'd2, 8'h22})) begin
                n_fail++; $display("FAIL contention_wport[%0d] got=%b/%0d/%h", i, wr_enb, wr_addr, wr_data);
            end
        end
        idle_inputs();
    endtask

    task automatic test_cross_port();
        drive_m(0, 1, 1, 4'd5, 8'h55);
        drive_m(1, 1, 0, 4'd6, 8'h00);
        #1;
        n_tests++;
        if ({m0_ready, m1_ready} !== 2'b11) begin n_fail++; $display("FAIL cross_ready got=%b required=11", {m0_ready, m1_ready}); end
        @(negedge clk);
        idle_inputs();
        n_tests++;
        if ({wr_enb, rd_enb, wr_addr, rd_addr} !== {2'b11, 4'd5, 4'd6}) begin
            n_fail++; $display("FAIL cross_ports got=%b%b/%0d/%0d required=11/5/6", wr_enb, rd_enb, wr_addr, rd_addr);
        end
        repeat (2) @(negedge clk);
        n_tests++;
        if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 8'h00, 1'b0}) begin
            n_fail++; $display("FAIL cross_resp got=%b/%h/%b required=1/00/0", m1_rvalid, m1_rdata, m0_rvalid);
        end
    endtask

    task automatic test_read_order();
        m_req(0, 1, 4'd0, 8'h10);
        m_req(0, 1, 4'd1, 8'h20);
        drive_m(0, 1, 0, 4'd0, 8'h00);
        #1;
        n_tests++;
        if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL order_r0_ready got=%b required=1", m0_ready); end
        @(negedge clk);
        drive_m(0, 0, 0, 4'd0, 8'h00);
        drive_m(1, 1, 0, 4'd1, 8'h00);
        #1;
        n_tests++;
        if (m1_ready !== 1'b1) begin n_fail++; $display("FAIL order_r1_ready got=%b required=1", m1_ready); end
        @(negedge clk);
        idle_inputs();
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m0_rdata, m1_rvalid} !== {1'b1, 8'h10, 1'b0}) begin
            n_fail++; $display("FAIL order_first got=%b/%h/%b required=1/10/0", m0_rvalid, m0_rdata, m1_rvalid);
        end
        @(negedge clk);
        n_tests++;
        if ({m1_rvalid, m1_rdata, m0_rvalid} !== {1'b1, 8'h20, 1'b0}) begin
            n_fail++; $display("FAIL order_second got=%b/%h/%b required=1/20/0", m1_rvalid, m1_rdata, m0_rvalid);
        end
    endtask

    task automatic test_clear();
        int rdy_hi, seq_err, done_cnt, busy_err, nz;
        rdy_hi = 0; seq_err = 0; done_cnt = 0; busy_err = 0; nz = 0;
        for (int a = 0; a < DEPTH; a++) m_req(0, 1, a[AW-1:0], 8'hFF);
        @(negedge clk);
        drive_m(0, 1, 0, 4'd0, 8'h00);
        for (int i = 0; i < 18; i++) begin
            clr_start = (i == 0 || i == 5);
            #1 if (m0_ready !== 1'b0) rdy_hi++;
            @(negedge clk);
            if (i >= 1 && i <= 16) begin
                if (!(wr_enb === 1'b1 && wr_addr === 4'(i - 1) && wr_data === 8'h00)) seq_err++;
            end else if (wr_enb !== 1'b0) seq_err++;
            if (rd_enb !== 1'b0) seq_err++;
            if (clr_done === 1'b1) begin done_cnt++; if (i != 16) seq_err++; end
            if (clr_busy !== (i <= 16)) busy_err++;
        end
        clr_start = 0;
        n_tests++;
        if (rdy_hi != 0) begin n_fail++; $display("FAIL clear_ready_blocked high_cycles=%0d required=0", rdy_hi); end
        n_tests++;
        if (seq_err != 0) begin n_fail++; $display("FAIL clear_wseq errors=%0d required=0", seq_err); end
        n_tests++;
        if (done_cnt != 1) begin n_fail++; $display("FAIL clear_done_pulses got=%0d required=1", done_cnt); end
        n_tests++;
        if (busy_err != 0) begin n_fail++; $display("FAIL clear_busy errors=%0d required=0", busy_err); end
        #1;
        n_tests++;
        if (m0_ready !== 1'b1) begin n_fail++; $display("FAIL clear_resume_ready got=%b required=1", m0_ready); end
        @(negedge clk);
        idle_inputs();
        repeat (3) @(negedge clk);
        for (int a = 0; a < DEPTH; a++) begin
            m_req(0, 0, a[AW-1:0], 8'h00);
            for (int w = 0; w < 6; w++) begin
                if (m0_rvalid === 1'b1) break;
                @(negedge clk);
            end
            if (m0_rvalid !== 1'b1 || m0_rdata !== 8'h00) nz++;
        end
        n_tests++;
        if (nz != 0) begin n_fail++; $display("FAIL clear_readback bad_locations=%0d required=0", nz); end
        n_tests++;
        if (clr_busy !== 1'b0) begin n_fail++; $display("FAIL clear_no_restart busy=%b required=0", clr_busy); end
    endtask

    task automatic test_reset_mid();
        bit found;
        int bad;
        logic [63:0] all;
        found = 0; bad = 0;
        m_req(0, 0, 4'd2, 8'h00);
        clr_start = 1;
        @(negedge clk);
        clr_start = 0;
        n_tests++;
        if (clr_busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got=%b required=1", clr_busy); end
        @(negedge clk);
        n_tests++;
        if ({m0_rvalid, m0_rdata, clr_busy} !== {1'b1, 8'h00, 1'b1}) begin
            n_fail++; $display("FAIL mid_inflight_return got=%b/%h/%b required=1/00/1", m0_rvalid, m0_rdata, clr_busy);
        end
        for (int w = 0; w < 30 && !found; w++) begin
            if (wr_enb === 1'b1 && wr_addr === 4'd7) found = 1;
            else @(negedge clk);
        end
        n_tests++;
        if (!found) begin n_fail++; $display("FAIL mid_reach_addr7 got=0 required=1"); end
        rst = 0;
        #1;
        all = {wr_enb, wr_addr, wr_data, rd_enb, rd_addr, m0_rvalid, m1_rvalid,
               m0_rdata, m1_rdata, clr_busy, clr_done, m0_ready, m1_ready};
        n_tests++;
        if (all !== 64'd0) begin n_fail++; $display("FAIL mid_reset_outputs got=%h required=0", all); end
        @(negedge clk);
        rst = 1;
        repeat (5) begin
            @(negedge clk);
            if (m0_rvalid !== 0 || m1_rvalid !== 0 || wr_enb !== 0 || clr_busy !== 0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_abandon bad_cycles=%0d required=0", bad); end
        m_req(0, 0, 4'd4, 8'h00);
        rst = 0;
        #1;
        n_tests++;
        if (rd_enb !== 1'b0) begin n_fail++; $display("FAIL mid_rd_enb_clear got=%b required=0", rd_enb); end
        @(negedge clk);
        rst = 1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (m0_rvalid !== 0 || m1_rvalid !== 0) bad++;
        end
        n_tests++;
        if (bad != 0) begin n_fail++; $display("FAIL mid_tag_drop rvalid_cycles=%0d required=0", bad); end
        drive_m(0, 1, 1, 4'd8, 8'h88);
        drive_m(1, 1, 1, 4'd9, 8'h99);
        #1;
        n_tests++;
        if ({m0_ready, m1_ready} !== 2'b10) begin n_fail++; $display("FAIL mid_first_winner got=%b required=10", {m0_ready, m1_ready}); end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_random();
        logic [DW-1:0] ref_mem [DEPTH];
        resp_t rq[$];
        resp_t r;
        bit pv [2]; bit pwe [2]; logic [AW-1:0] pa [2]; logic [DW-1:0] pd [2];
        int wlast, rlast;
        bit gw0, gw1, gr0, gr1, e0, e1, w0, w1, r0, r1, gone;
        bit exp_wv, exp_rv;
        logic [AW-1:0] exp_wa, exp_ra, a;
        logic [DW-1:0] exp_wd;
        do_reset();
        @(negedge clk);
        clr_start = 1;
        @(negedge clk);
        clr_start = 0;
        gone = 0;
        for (int w = 0; w < 40 && !gone; w++) begin
            if (clr_busy === 1'b0) gone = 1;
            else @(negedge clk);
        end
        n_tests++;
        if (!gone) begin n_fail++; $display("FAIL rand_clear_timeout busy=%b required=0", clr_busy); end
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        wlast = 1; rlast = 1;
        exp_wv = 0; exp_rv = 0; exp_wa = '0; exp_ra = '0; exp_wd = '0;
        for (int j = 0; j < 2; j++) begin pv[j] = 0; pwe[j] = 0; pa[j] = '0; pd[j] = '0; end
        for (int k = 0; k < 406; k++) begin
            n_tests++;
            if (wr_enb !== exp_wv || (exp_wv && {wr_addr, wr_data} !== {exp_wa, exp_wd})) begin
                n_fail++; $display("FAIL rand_wport cyc=%0d got=%b/%0d/%h required=%b/%0d/%h", k, wr_enb, wr_addr, wr_data, exp_wv, exp_wa, exp_wd);
            end
            n_tests++;
            if (rd_enb !== exp_rv || (exp_rv && rd_addr !== exp_ra)) begin
                n_fail++; $display("FAIL rand_rport cyc=%0d got=%b/%0d required=%b/%0d", k, rd_enb, rd_addr, exp_rv, exp_ra);
            end
            e0 = rq.size() > 0 && rq[0].due == k && rq[0].id == 0;
            e1 = rq.size() > 0 && rq[0].due == k && rq[0].id == 1;
            n_tests++;
            if ({m0_rvalid, m1_rvalid} !== {e0, e1}) begin
                n_fail++; $display("FAIL rand_rvalid cyc=%0d got=%b required=%b", k, {m0_rvalid, m1_rvalid}, {e0, e1});
            end
            if (e0 || e1) begin
                n_tests++;
                if ((e0 ? m0_rdata : m1_rdata) !== rq[0].data) begin
                    n_fail++; $display("FAIL rand_rdata cyc=%0d id=%0d got=%h required=%h", k, e1, e0 ? m0_rdata : m1_rdata, rq[0].data);
                end
                void'(rq.pop_front());
            end
            for (int j = 0; j < 2; j++) begin
                if (k < 400 && !pv[j] && $urandom_range(0, 3) != 0) begin
                    pv[j] = 1; pwe[j] = $urandom_range(0, 1) == 1;
                    pa[j] = AW'($urandom); pd[j] = DW'($urandom);
                end
                drive_m(j[0], pv[j], pwe[j], pa[j], pd[j]);
            end
            w0 = pv[0] && pwe[0];  w1 = pv[1] && pwe[1];
            r0 = pv[0] && !pwe[0]; r1 = pv[1] && !pwe[1];
            gw0 = w0 && (!w1 || wlast == 1); gw1 = w1 && (!w0 || wlast == 0);
            gr0 = r0 && (!r1 || rlast == 1); gr1 = r1 && (!r0 || rlast == 0);
            #1;
            n_tests++;
            if ({m0_ready, m1_ready} !== {gw0 | gr0, gw1 | gr1}) begin
                n_fail++; $display("FAIL rand_ready cyc=%0d got=%b required=%b", k, {m0_ready, m1_ready}, {gw0 | gr0, gw1 | gr1});
            end
            exp_rv = gr0 | gr1;
            if (exp_rv) begin
                a = gr0 ? pa[0] : pa[1];
                r.due = k + 3; r.id = gr1; r.data = ref_mem[a];
                rq.push_back(r);
                exp_ra = a; rlast = gr1 ? 1 : 0;
            end
            exp_wv = gw0 | gw1;
            if (exp_wv) begin
                exp_wa = gw0 ? pa[0] : pa[1];
                exp_wd = gw0 ? pd[0] : pd[1];
                ref_mem[exp_wa] = exp_wd;
                wlast = gw1 ? 1 : 0;
            end
            if (gw0 || gr0) pv[0] = 0;
            if (gw1 || gr1) pv[1] = 0;
            @(negedge clk);
        end
        idle_inputs();
        n_tests++;
        if (rq.size() != 0) begin n_fail++; $display("FAIL rand_drain outstanding=%0d required=0", rq.size()); end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog simulation_time_exceeded");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_inputs();
        rst = 0;
        test_reset();
        test_single_write_read();
        do_reset();
        test_write_contention();
        test_cross_port();
        test_read_order();
        test_clear();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
